// File: rtl/md_sched_pkg.sv
// md_sched_pkg: MD op codes, sequencer states and op-class helpers
package md_sched_pkg;
  localparam int MD_OP_LEN = 4;
  typedef enum logic [MD_OP_LEN-1:0] {
    MD_OP_NONE  = 4'd0,
    MD_OP_MULT  = 4'd1,
    MD_OP_MULTU = 4'd2,
    MD_OP_DIV   = 4'd3,
    MD_OP_DIVU  = 4'd4,
    MD_OP_MTHI  = 4'd5,
    MD_OP_MTLO  = 4'd6,
    MD_OP_MFHI  = 4'd7,
    MD_OP_MFLO  = 4'd8
  } md_op_e;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic logic is_arith(logic [MD_OP_LEN-1:0] op);
    return op == MD_OP_MULT || op == MD_OP_MULTU || op == MD_OP_DIV || op == MD_OP_DIVU;
  endfunction
  function automatic logic is_mul(logic [MD_OP_LEN-1:0] op);
    return op == MD_OP_MULT || op == MD_OP_MULTU;
  endfunction
endpackage

// File: rtl/md_result.sv
// md_result: combinational {hi,lo} for a latched MULT/MULTU/DIV/DIVU op
module md_result
  import md_sched_pkg::*;
(
  input  logic [MD_OP_LEN-1:0] op,
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  output logic [63:0]          res
);
  logic        sg_mul, sg_div;
  logic [63:0] mul;
  logic [31:0] da, db, q, r, sq, sr;
  always_comb begin
    sg_mul = op == MD_OP_MULT;
    sg_div = op == MD_OP_DIV;
    mul = {{32{sg_mul & a[31]}}, a} * {{32{sg_mul & b[31]}}, b};
    da = (sg_div & a[31]) ? -a : a;
    db = (sg_div & b[31]) ? -b : b;
    q = db == '0 ? '0 : da / db;
    r = db == '0 ? '0 : da % db;
    sq = (sg_div & (a[31] ^ b[31])) ? -q : q;
    sr = (sg_div & a[31]) ? -r : r;
    res = is_mul(op) ? mul : b == '0 ? {a, 32'hFFFF_FFFF} : {sr, sq};
  end
endmodule

// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer owning HI/LO with decode stall
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  input  logic [MD_OP_LEN-1:0] op,
  input  logic [31:0]          rs_val,
  input  logic [31:0]          rt_val,
  input  logic                 cancel,
  input  logic                 d_is_md,
  output logic                 busy,
  output logic                 stall,
  output logic [31:0]          hi,
  output logic [31:0]          lo,
  output logic [31:0]          rd_data,
  output logic                 err_overlap
);
  state_e               state;
  logic [3:0]           count;
  logic [MD_OP_LEN-1:0] l_op;
  logic [31:0]          l_a, l_b;
  logic [63:0]          res;
  logic                 issue;
  md_result u_res (.op(l_op), .a(l_a), .b(l_b), .res(res));
  assign issue   = op_valid & ~cancel & state == IDLE & is_arith(op);
  assign busy    = state == RUN | issue;
  assign stall   = d_is_md & busy;
  assign rd_data = op == MD_OP_MFHI ? hi : op == MD_OP_MFLO ? lo : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      hi          <= '0;
      lo          <= '0;
      err_overlap <= 1'b0;
      l_op        <= MD_OP_NONE;
      l_a         <= '0;
      l_b         <= '0;
    end else if (state == IDLE) begin
      if (issue) begin
        l_op  <= op;
        l_a   <= rs_val;
        l_b   <= rt_val;
        count <= is_mul(op) ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
        state <= RUN;
      end else if (op_valid & ~cancel) begin
        if (op == MD_OP_MTHI) hi <= rs_val;
        if (op == MD_OP_MTLO) lo <= rs_val;
      end
    end else begin
      count <= count - 4'd1;
      if (count == 4'd1) begin
        {hi, lo} <= res;
        state    <= IDLE;
      end
      if (op_valid & op != MD_OP_NONE) err_overlap <= 1'b1;
    end
  end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed plus random check of md_sched against an arithmetic model
module tb_md_sched;
  import md_sched_pkg::*;
  localparam int MUL = 5;
  localparam int DIV = 10;
  logic                 clk = 1'b0;
  logic                 reset, op_valid, cancel, d_is_md;
  logic [MD_OP_LEN-1:0] op;
  logic [31:0]          rs_val, rt_val;
  logic                 busy, stall, err_overlap;
  logic [31:0]          hi, lo, rd_data;
  int                   checks = 0;
  int                   failures = 0;
  logic [31:0]          m_hi, m_lo;
  logic                 m_err;
  logic [63:0]          pend;
  int                   rem;
  md_sched #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .cancel(cancel), .d_is_md(d_is_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo),
    .rd_data(rd_data), .err_overlap(err_overlap)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_res(logic [MD_OP_LEN-1:0] o, logic [31:0] a, logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = {32'b0, a};
    longint ub = {32'b0, b};
    if (o == MD_OP_MULT) return sa * sb;
    if (o == MD_OP_MULTU) return ua * ub;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (o == MD_OP_DIV) return {32'(sa % sb), 32'(sa / sb)};
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1; op_valid = 1'b0; op = MD_OP_NONE; rs_val = '0; rt_val = '0; cancel = 1'b0; d_is_md = 1'b0;
    @(posedge clk);
    m_hi = '0; m_lo = '0; m_err = 1'b0; rem = 0; pend = '0;
    #1;
    reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_err", 64'(err_overlap), 64'(0));
  endtask
  task automatic cyc(input logic v, input logic [MD_OP_LEN-1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic c, input logic d);
    logic idle, iss;
    op_valid = v; op = o; rs_val = a; rt_val = b; cancel = c; d_is_md = d; reset = 1'b0;
    #1;
    idle = rem == 0;
    iss = v && !c && idle && is_arith(o);
    check("busy", 64'(busy), 64'(!idle || iss));
    check("stall", 64'(stall), 64'(d && (!idle || iss)));
    check("rd_data", 64'(rd_data), 64'(o == MD_OP_MFHI ? m_hi : o == MD_OP_MFLO ? m_lo : 32'h0));
    @(posedge clk);
    if (!idle) begin
      if (v && o != MD_OP_NONE) m_err = 1'b1;
      rem--;
      if (rem == 0) {m_hi, m_lo} = pend;
    end else if (iss) begin
      pend = ref_res(o, a, b);
      rem = is_mul(o) ? MUL : DIV;
    end else if (v && !c) begin
      if (o == MD_OP_MTHI) m_hi = a;
      if (o == MD_OP_MTLO) m_lo = a;
    end
    #1;
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("err", 64'(err_overlap), 64'(m_err));
  endtask
  task automatic idle_cycles(input int n, input logic d);
    for (int i = 0; i < n; i++) cyc(1'b0, MD_OP_NONE, '0, '0, 1'b0, d);
  endtask
  task automatic run_op(input logic [MD_OP_LEN-1:0] o, input logic [31:0] a, input logic [31:0] b);
    cyc(1'b1, o, a, b, 1'b0, 1'b0);
    idle_cycles(is_mul(o) ? MUL : DIV, 1'b0);
  endtask
  function automatic logic [31:0] rand_val();
    int k = $urandom_range(0, 7);
    return k == 0 ? 32'h0 : k == 1 ? 32'h1 : k == 2 ? 32'hFFFF_FFFF : k == 3 ? 32'h8000_0000 :
           k == 4 ? 32'h7FFF_FFFF : k == 5 ? 32'($urandom_range(0, 20)) : $urandom;
  endfunction
  initial begin
    do_reset();
    cyc(1'b1, MD_OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    idle_cycles(MUL + 1, 1'b1);
    check("mult_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("mult_lo", 64'(lo), 64'(32'hFFFF_FFF1));
    cyc(1'b1, MD_OP_MFLO, '0, '0, 1'b0, 1'b0);
    run_op(MD_OP_DIVU, 32'd7, 32'd2);
    check("divu_lo", 64'(lo), 64'(32'd3));
    check("divu_hi", 64'(hi), 64'(32'd1));
    run_op(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_lo", 64'(lo), 64'(32'hFFFF_FFFD));
    check("div_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    run_op(MD_OP_DIV, 32'h1234_5678, 32'd0);
    check("div0_lo", 64'(lo), 64'(32'hFFFF_FFFF));
    check("div0_hi", 64'(hi), 64'(32'h1234_5678));
    run_op(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_lo", 64'(lo), 64'(32'h8000_0000));
    check("ovf_hi", 64'(hi), 64'(32'h0));
    cyc(1'b1, MD_OP_MULT, 32'd9, 32'd9, 1'b1, 1'b0);
    idle_cycles(2, 1'b1);
    check("cancel_lo", 64'(lo), 64'(32'h8000_0000));
    cyc(1'b1, MD_OP_MTHI, 32'hDEAD_BEEF, '0, 1'b1, 1'b0);
    check("mthi_cancel", 64'(hi), 64'(32'h0));
    cyc(1'b1, MD_OP_MTHI, 32'h5555_AAAA, '0, 1'b0, 1'b0);
    check("mthi", 64'(hi), 64'(32'h5555_AAAA));
    cyc(1'b1, MD_OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
    cyc(1'b1, MD_OP_MTHI, 32'h1111_1111, '0, 1'b0, 1'b0);
    check("overlap_err", 64'(err_overlap), 64'(1));
    idle_cycles(DIV - 1, 1'b0);
    check("overlap_q", 64'(lo), 64'(32'd14));
    check("overlap_r", 64'(hi), 64'(32'd2));
    cyc(1'b1, MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle_cycles(3, 1'b0);
    do_reset();
    cyc(1'b1, MD_OP_MTLO, 32'h0000_ABCD, '0, 1'b0, 1'b0);
    op_valid = 1'b1; op = MD_OP_MFLO;
    #1;
    check("mflo_abcd", 64'(rd_data), 64'(32'h0000_ABCD));
    cyc(1'b1, MD_OP_MFLO, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      logic v;
      logic [MD_OP_LEN-1:0] o;
      v = rem > 0 ? $urandom_range(0, 19) == 0 : $urandom_range(0, 9) < 7;
      o = v ? MD_OP_LEN'($urandom_range(1, 8)) : MD_OP_NONE;
      cyc(v, o, rand_val(), rand_val(), $urandom_range(0, 4) == 0, 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
